// File: rtl/unified_mem_arbiter_if.sv
// Purpose: bundles the fetch, data, memory and stall signals of unified_mem_arbiter.
// Signals:
//   in_if_req/in_if_addr, out_if_rdata/out_if_valid      instruction fetch port
//   in_dm_req/wena/type/addr/wdata, out_dm_rdata/valid   data (MEM stage) port
//   out_mem_ena/wena/type/addr/wdata, in_mem_rdata        single-port memory side
//   out_stall                                             global pipeline stall
// Modports: master = arbiter view, slave = environment (pipeline + memory) view.
interface unified_mem_arbiter_if;
   localparam int unsigned XLEN   = 32;
   localparam int unsigned TYPE_W = 2;

   logic              in_if_req;
   logic [XLEN-1:0]   in_if_addr;
   logic [XLEN-1:0]   out_if_rdata;
   logic              out_if_valid;

   logic              in_dm_req;
   logic              in_dm_wena;
   logic [TYPE_W-1:0] in_dm_type;
   logic [XLEN-1:0]   in_dm_addr;
   logic [XLEN-1:0]   in_dm_wdata;
   logic [XLEN-1:0]   out_dm_rdata;
   logic              out_dm_valid;

   logic              out_mem_ena;
   logic              out_mem_wena;
   logic [TYPE_W-1:0] out_mem_type;
   logic [XLEN-1:0]   out_mem_addr;
   logic [XLEN-1:0]   out_mem_wdata;
   logic [XLEN-1:0]   in_mem_rdata;

   logic              out_stall;

   modport master (
      input  in_if_req, in_if_addr,
      input  in_dm_req, in_dm_wena, in_dm_type, in_dm_addr, in_dm_wdata,
      input  in_mem_rdata,
      output out_if_rdata, out_if_valid,
      output out_dm_rdata, out_dm_valid,
      output out_mem_ena, out_mem_wena, out_mem_type, out_mem_addr, out_mem_wdata,
      output out_stall
   );

   modport slave (
      output in_if_req, in_if_addr,
      output in_dm_req, in_dm_wena, in_dm_type, in_dm_addr, in_dm_wdata,
      output in_mem_rdata,
      input  out_if_rdata, out_if_valid,
      input  out_dm_rdata, out_dm_valid,
      input  out_mem_ena, out_mem_wena, out_mem_type, out_mem_addr, out_mem_wdata,
      input  out_stall
   );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Purpose: shares one single-port unified memory between instruction fetch and the
//          data port. Each access runs IDLE -> ISSUE -> WAIT -> RESP with a one-cycle
//          memory strobe and a one-cycle completion pulse; out_stall holds the
//          pipeline while any request is unserved.
// Ports:
//   in_clk  clock, all state on the rising edge
//   in_rst  synchronous active-high reset
//   bus     unified_mem_arbiter_if.master (fetch, data, memory, stall)
// Parameters: MEM_LATENCY (>=1, strobe-to-rdata cycles), MAX_DM_STREAK.
// Optional feature: define ARB_FETCH_FAIR_EN to force a fetch grant after
//   MAX_DM_STREAK consecutive data grants seen with a fetch pending.
module unified_mem_arbiter #(
   parameter int unsigned MEM_LATENCY   = 1,
   parameter int unsigned MAX_DM_STREAK = 4
) (
   input logic                   in_clk,
   input logic                   in_rst,
   unified_mem_arbiter_if.master bus
);
   localparam int unsigned XLEN   = 32;
   localparam int unsigned TYPE_W = 2;
   localparam int unsigned CNT_W  = $clog2(MEM_LATENCY + 1);
   // Instruction fetch is always a full-word access.
   localparam logic [TYPE_W-1:0] FETCH_TYPE = TYPE_W'(2);

   if (MEM_LATENCY < 1) begin : g_bad_latency
      $error("MEM_LATENCY must be >= 1");
   end
   if (MAX_DM_STREAK < 1) begin : g_bad_streak
      $error("MAX_DM_STREAK must be >= 1");
   end

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

   state_t              state_q, state_d;
   logic                owner_q, owner_d;          // 1: data port owns the access
   logic                mem_ena_q, mem_ena_d;
   logic                mem_wena_q, mem_wena_d;
   logic [TYPE_W-1:0]   mem_type_q, mem_type_d;
   logic [XLEN-1:0]     mem_addr_q, mem_addr_d;
   logic [XLEN-1:0]     mem_wdata_q, mem_wdata_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [XLEN-1:0]     if_rdata_q, if_rdata_d;
   logic [XLEN-1:0]     dm_rdata_q, dm_rdata_d;
   logic                if_valid_q, if_valid_d;
   logic                dm_valid_q, dm_valid_d;
   logic                force_fetch;
   logic                grant_dm;
   logic                grant_if;

   // Data wins unless the fairness logic is forcing a fetch.
   assign grant_dm = bus.in_dm_req && !force_fetch;
   assign grant_if = bus.in_if_req && !grant_dm;

`ifdef ARB_FETCH_FAIR_EN
   localparam int unsigned STREAK_W = $clog2(MAX_DM_STREAK + 1);
   logic [STREAK_W-1:0] streak_q, streak_d;

   assign force_fetch = bus.in_if_req && (streak_q == STREAK_W'(MAX_DM_STREAK));

   // Count data grants that bypassed a pending fetch; a fetch grant clears it.
   always_comb begin
      streak_d = streak_q;
      if (state_q == S_IDLE) begin
         if (grant_if) begin
            streak_d = '0;
         end else if (grant_dm && bus.in_if_req) begin
            streak_d = streak_q + STREAK_W'(1);
         end
      end
   end

   always_ff @(posedge in_clk) begin
      if (in_rst) streak_q <= '0;
      else        streak_q <= streak_d;
   end
`else
   assign force_fetch = 1'b0;
`endif

   // Next state and next values of every registered output.
   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      mem_ena_d   = 1'b0;
      mem_wena_d  = mem_wena_q;
      mem_type_d  = mem_type_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      cnt_d       = cnt_q;
      if_rdata_d  = if_rdata_q;
      dm_rdata_d  = dm_rdata_q;
      if_valid_d  = 1'b0;
      dm_valid_d  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (grant_dm || grant_if) begin
               owner_d     = grant_dm;
               mem_ena_d   = 1'b1;   // strobe is high for the whole ISSUE cycle
               mem_wena_d  = grant_dm && bus.in_dm_wena;
               mem_type_d  = grant_dm ? bus.in_dm_type : FETCH_TYPE;
               mem_addr_d  = grant_dm ? bus.in_dm_addr : bus.in_if_addr;
               mem_wdata_d = grant_dm ? bus.in_dm_wdata : '0;
               state_d     = S_ISSUE;
            end
         end
         S_ISSUE: begin
            cnt_d   = CNT_W'(MEM_LATENCY - 1);
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (cnt_q == '0) begin
               if (!owner_q) begin
                  if_rdata_d = bus.in_mem_rdata;
               end else if (!mem_wena_q) begin
                  dm_rdata_d = bus.in_mem_rdata;
               end
               if_valid_d = !owner_q;
               dm_valid_d = owner_q;
               state_d    = S_RESP;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge in_clk) begin
      if (in_rst) begin
         state_q     <= S_IDLE;
         owner_q     <= 1'b0;
         mem_ena_q   <= 1'b0;
         mem_wena_q  <= 1'b0;
         mem_type_q  <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         cnt_q       <= '0;
         if_rdata_q  <= '0;
         dm_rdata_q  <= '0;
         if_valid_q  <= 1'b0;
         dm_valid_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         mem_ena_q   <= mem_ena_d;
         mem_wena_q  <= mem_wena_d;
         mem_type_q  <= mem_type_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         cnt_q       <= cnt_d;
         if_rdata_q  <= if_rdata_d;
         dm_rdata_q  <= dm_rdata_d;
         if_valid_q  <= if_valid_d;
         dm_valid_q  <= dm_valid_d;
      end
   end

   assign bus.out_mem_ena   = mem_ena_q;
   assign bus.out_mem_wena  = mem_wena_q;
   assign bus.out_mem_type  = mem_type_q;
   assign bus.out_mem_addr  = mem_addr_q;
   assign bus.out_mem_wdata = mem_wdata_q;
   assign bus.out_if_rdata  = if_rdata_q;
   assign bus.out_if_valid  = if_valid_q;
   assign bus.out_dm_rdata  = dm_rdata_q;
   assign bus.out_dm_valid  = dm_valid_q;

   // Stall drops in the same cycle the completion pulse appears.
   assign bus.out_stall = !in_rst &&
                          ((bus.in_if_req && !if_valid_q) || (bus.in_dm_req && !dm_valid_q));
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Purpose: directed, table-driven bench for unified_mem_arbiter. dut1 uses
//          MEM_LATENCY=1, dut3 uses MEM_LATENCY=3; each has a memory model that
//          returns valid data only exactly MEM_LATENCY cycles after the strobe.
module tb_unified_mem_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   unified_mem_arbiter_if bus1();
   unified_mem_arbiter_if bus3();

   unified_mem_arbiter #(.MEM_LATENCY(1), .MAX_DM_STREAK(4)) dut1 (
      .in_clk (clk),
      .in_rst (rst),
      .bus    (bus1)
   );

   unified_mem_arbiter #(.MEM_LATENCY(3), .MAX_DM_STREAK(4)) dut3 (
      .in_clk (clk),
      .in_rst (rst),
      .bus    (bus3)
   );

   int checks = 0;
   int errors = 0;

   function automatic logic [31:0] mem_data(input logic [31:0] a);
      return (a == 32'h0000_0010) ? 32'h2408_0005 : (a ^ 32'hA5A5_0000);
   endfunction

   // Memory models: read data is only meaningful exactly MEM_LATENCY cycles after the strobe.
   logic [3:0] p1 = '0;
   logic [3:0] p3 = '0;
   always @(posedge clk) begin
      p1 <= {p1[2:0], bus1.out_mem_ena};
      p3 <= {p3[2:0], bus3.out_mem_ena};
   end
   assign bus1.in_mem_rdata = p1[0] ? mem_data(bus1.out_mem_addr) : 32'h0BAD_0BAD;
   assign bus3.in_mem_rdata = p3[2] ? mem_data(bus3.out_mem_addr) : 32'h0BAD_0BAD;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        is_dm;
      logic        wena;
      logic [1:0]  dtype;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        exp_wena;
      int          exp_valid_idx;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs[6];

   // One isolated transaction on dut1; indices count falling edges after the request.
   task automatic run_vec(input vec_t v, input string tag);
      int          ena_idx = -1;
      int          ena_cnt = 0;
      int          own_idx = -1;
      int          own_cnt = 0;
      int          oth_cnt = 0;
      logic [31:0] s_addr  = '0;
      logic [31:0] s_wdata = '0;
      logic        s_wena  = 1'b0;
      logic [1:0]  s_type  = '0;
      logic        own_v;
      logic        oth_v;
      if (v.is_dm) begin
         bus1.in_dm_req   = 1'b1;
         bus1.in_dm_wena  = v.wena;
         bus1.in_dm_type  = v.dtype;
         bus1.in_dm_addr  = v.addr;
         bus1.in_dm_wdata = v.wdata;
      end else begin
         bus1.in_if_req  = 1'b1;
         bus1.in_if_addr = v.addr;
      end
      #1 chk({tag, "_stall_on_req"}, 32'(bus1.out_stall), 32'd1);
      for (int i = 1; i <= 6; i++) begin
         @(negedge clk);
         own_v = v.is_dm ? bus1.out_dm_valid : bus1.out_if_valid;
         oth_v = v.is_dm ? bus1.out_if_valid : bus1.out_dm_valid;
         if (bus1.out_mem_ena) begin
            ena_cnt++;
            if (ena_idx < 0) begin
               ena_idx = i;
               s_addr  = bus1.out_mem_addr;
               s_wdata = bus1.out_mem_wdata;
               s_wena  = bus1.out_mem_wena;
               s_type  = bus1.out_mem_type;
            end
         end
         if (i == 2) chk({tag, "_stall_wait"}, 32'(bus1.out_stall), 32'd1);
         if (oth_v) oth_cnt++;
         if (own_v) begin
            own_cnt++;
            if (own_idx < 0) begin
               own_idx = i;
               chk({tag, "_stall_at_valid"}, 32'(bus1.out_stall), 32'd0);
            end
            bus1.in_dm_req = 1'b0;
            bus1.in_if_req = 1'b0;
         end
      end
      chk({tag, "_ena_idx"},   ena_idx, 32'd1);
      chk({tag, "_ena_cnt"},   ena_cnt, 32'd1);
      chk({tag, "_valid_idx"}, own_idx, v.exp_valid_idx);
      chk({tag, "_valid_cnt"}, own_cnt, 32'd1);
      chk({tag, "_other_valid_cnt"}, oth_cnt, 32'd0);
      chk({tag, "_mem_addr"},  s_addr, v.addr);
      chk({tag, "_mem_wena"},  32'(s_wena), 32'(v.exp_wena));
      if (v.is_dm) begin
         chk({tag, "_mem_wdata"}, s_wdata, v.wdata);
         chk({tag, "_mem_type"},  32'(s_type), 32'(v.dtype));
         chk({tag, "_dm_rdata"},  bus1.out_dm_rdata, v.exp_rdata);
      end else begin
         chk({tag, "_if_rdata"},  bus1.out_if_rdata, v.exp_rdata);
      end
   endtask

   initial begin
      int   d_ena1, d_ena2, d_dval, d_ival;
      logic [31:0] a_ena1, a_ena2;
      int   ena_seen;
      int   dm_grants, dm_before;
      logic fetch_seen;
      vec_t fv;

      // {is_dm, wena, type, addr, wdata, exp_wena, exp_valid_idx, exp_rdata}
      vecs[0] = '{1'b0, 1'b0, 2'd0, 32'h0000_0010, 32'h0,          1'b0, 3, 32'h2408_0005};
      vecs[1] = '{1'b1, 1'b0, 2'd2, 32'h0000_0100, 32'h0,          1'b0, 3, 32'hA5A5_0100};
      vecs[2] = '{1'b1, 1'b1, 2'd2, 32'h0000_0200, 32'hDEAD_BEEF,  1'b1, 3, 32'hA5A5_0100};
      vecs[3] = '{1'b0, 1'b0, 2'd0, 32'h0000_0044, 32'h0,          1'b0, 3, 32'hA5A5_0044};
      vecs[4] = '{1'b1, 1'b0, 2'd0, 32'h0000_0203, 32'h0,          1'b0, 3, 32'hA5A5_0203};
      vecs[5] = '{1'b1, 1'b1, 2'd1, 32'h0000_0002, 32'h0000_1234,  1'b1, 3, 32'hA5A5_0203};

      bus1.in_if_req = 1'b1;  bus1.in_if_addr = '0;
      bus1.in_dm_req = 1'b0;  bus1.in_dm_wena = 1'b0; bus1.in_dm_type = '0;
      bus1.in_dm_addr = '0;   bus1.in_dm_wdata = '0;
      bus3.in_if_req = 1'b0;  bus3.in_if_addr = '0;
      bus3.in_dm_req = 1'b0;  bus3.in_dm_wena = 1'b0; bus3.in_dm_type = '0;
      bus3.in_dm_addr = '0;   bus3.in_dm_wdata = '0;

      // Reset for two cycles; a pending fetch must not raise stall during reset.
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      chk("rst_mem_ena",  32'(bus1.out_mem_ena),  32'd0);
      chk("rst_if_valid", 32'(bus1.out_if_valid), 32'd0);
      chk("rst_dm_valid", 32'(bus1.out_dm_valid), 32'd0);
      chk("rst_if_rdata", bus1.out_if_rdata, 32'd0);
      chk("rst_dm_rdata", bus1.out_dm_rdata, 32'd0);
      chk("rst_mem_addr", bus1.out_mem_addr, 32'd0);
      chk("rst_mem_wena", 32'(bus1.out_mem_wena), 32'd0);
      chk("rst_stall",    32'(bus1.out_stall),    32'd0);
      chk("rst_mem_ena3", 32'(bus3.out_mem_ena),  32'd0);
      bus1.in_if_req = 1'b0;
      rst = 1'b0;
      @(negedge clk);

      for (int k = 0; k < 6; k++) begin
         run_vec(vecs[k], $sformatf("v%0d", k));
      end

      // Simultaneous fetch and load: data first, fetch at the following IDLE.
      d_ena1 = -1; d_ena2 = -1; d_dval = -1; d_ival = -1;
      a_ena1 = '0; a_ena2 = '0; ena_seen = 0;
      bus1.in_dm_req = 1'b1; bus1.in_dm_wena = 1'b0; bus1.in_dm_type = 2'd2;
      bus1.in_dm_addr = 32'h0000_0100;
      bus1.in_if_req = 1'b1; bus1.in_if_addr = 32'h0000_0010;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         if (bus1.out_mem_ena) begin
            ena_seen++;
            if (ena_seen == 1) begin d_ena1 = i; a_ena1 = bus1.out_mem_addr; end
            if (ena_seen == 2) begin d_ena2 = i; a_ena2 = bus1.out_mem_addr; end
         end
         if (i == 3) chk("both_stall_fetch_pending", 32'(bus1.out_stall), 32'd1);
         if (i == 7) chk("both_stall_fetch_valid",   32'(bus1.out_stall), 32'd0);
         if (bus1.out_dm_valid && d_dval < 0) begin d_dval = i; bus1.in_dm_req = 1'b0; end
         if (bus1.out_if_valid && d_ival < 0) begin d_ival = i; bus1.in_if_req = 1'b0; end
      end
      chk("both_ena1_idx",  d_ena1, 32'd1);
      chk("both_ena1_addr", a_ena1, 32'h0000_0100);
      chk("both_dm_valid",  d_dval, 32'd3);
      chk("both_ena2_idx",  d_ena2, 32'd5);
      chk("both_ena2_addr", a_ena2, 32'h0000_0010);
      chk("both_if_valid",  d_ival, 32'd7);
      chk("both_ena_cnt",   ena_seen, 32'd2);
      chk("both_dm_rdata",  bus1.out_dm_rdata, 32'hA5A5_0100);
      chk("both_if_rdata",  bus1.out_if_rdata, 32'h2408_0005);

      // Reset during WAIT aborts the access with no completion pulse.
      bus1.in_dm_req = 1'b1; bus1.in_dm_wena = 1'b0; bus1.in_dm_type = 2'd2;
      bus1.in_dm_addr = 32'h0000_0150;
      @(negedge clk);
      chk("abort_ena", 32'(bus1.out_mem_ena), 32'd1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_dm_valid", 32'(bus1.out_dm_valid), 32'd0);
      chk("abort_mem_ena",  32'(bus1.out_mem_ena),  32'd0);
      chk("abort_mem_addr", bus1.out_mem_addr, 32'd0);
      chk("abort_dm_rdata", bus1.out_dm_rdata, 32'd0);
      chk("abort_if_rdata", bus1.out_if_rdata, 32'd0);
      chk("abort_stall",    32'(bus1.out_stall), 32'd0);
      rst = 1'b0;
      bus1.in_dm_req = 1'b0;
      @(negedge clk);
      chk("abort_no_late_valid", 32'(bus1.out_dm_valid), 32'd0);
      chk("abort_no_late_ena",   32'(bus1.out_mem_ena),  32'd0);
      fv = '{1'b0, 1'b0, 2'd0, 32'h0000_0010, 32'h0, 1'b0, 3, 32'h2408_0005};
      run_vec(fv, "after_abort");

      // MEM_LATENCY=3 load: valid five cycles after the request is first seen.
      d_ena1 = -1; d_dval = -1; ena_seen = 0; d_ival = 0;
      bus3.in_dm_req = 1'b1; bus3.in_dm_wena = 1'b0; bus3.in_dm_type = 2'd2;
      bus3.in_dm_addr = 32'h0000_0180;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         if (bus3.out_mem_ena) begin
            ena_seen++;
            if (d_ena1 < 0) d_ena1 = i;
         end
         if (bus3.out_dm_valid) begin
            d_ival++;
            if (d_dval < 0) d_dval = i;
            bus3.in_dm_req = 1'b0;
         end
      end
      chk("lat3_ena_idx",   d_ena1, 32'd1);
      chk("lat3_ena_cnt",   ena_seen, 32'd1);
      chk("lat3_valid_idx", d_dval, 32'd5);
      chk("lat3_valid_cnt", d_ival, 32'd1);
      chk("lat3_rdata",     bus3.out_dm_rdata, 32'hA5A5_0180);

      // Both requests held high: count data grants before the first fetch grant.
      dm_grants = 0; dm_before = -1; fetch_seen = 1'b0;
      bus1.in_dm_req = 1'b1; bus1.in_dm_wena = 1'b0; bus1.in_dm_type = 2'd2;
      bus1.in_dm_addr = 32'h0000_0300;
      bus1.in_if_req = 1'b1; bus1.in_if_addr = 32'h0000_0010;
      for (int i = 0; i < 200 && !fetch_seen && dm_grants < 20; i++) begin
         @(negedge clk);
         if (bus1.out_mem_ena) begin
            if (bus1.out_mem_addr == 32'h0000_0010) begin
               fetch_seen = 1'b1;
               dm_before  = dm_grants;
            end else begin
               dm_grants++;
            end
         end
      end
`ifdef ARB_FETCH_FAIR_EN
      chk("fair_fetch_granted",     32'(fetch_seen), 32'd1);
      chk("fair_dm_before_fetch",   dm_before, 32'd4);
`else
      chk("strict_no_fetch_grant",  32'(fetch_seen), 32'd0);
      chk("strict_dm_grants",       dm_grants, 32'd20);
`endif
      bus1.in_dm_req = 1'b0;
      bus1.in_if_req = 1'b0;
      repeat (8) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
